reorder_buffer_mp: RTL



---
 rtl/reorder_buffer_mp.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/reorder_buffer_mp.sv
// Multi-port reorder buffer: in-order allocate/retire, out-of-order result writes
// by tag, and youngest-match register forwarding for the bypass controller.
module reorder_buffer_mp #(
   parameter  int DEPTH   = 16,
   parameter  int DATA_W  = 32,
   parameter  int NUM_WR  = 3,
   parameter  int NUM_FWD = 2,
   localparam int TAG_W   = $clog2(DEPTH)
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic                      flush_i,
   input  logic                      alloc_i,
   input  logic [4:0]                alloc_dest_i,
   output logic [TAG_W-1:0]          alloc_tag_o,
   output logic                      full_o,
   output logic                      empty_o,
   output logic [TAG_W:0]            count_o,
   input  logic [NUM_WR-1:0]         wr_valid_i,
   input  logic [NUM_WR*TAG_W-1:0]   wr_tag_i,
   input  logic [NUM_WR*DATA_W-1:0]  wr_result_i,
   input  logic [NUM_WR-1:0]         wr_exception_i,
   input  logic [NUM_WR*5-1:0]       wr_vector_i,
   input  logic [NUM_FWD*5-1:0]      fwd_src_i,
   output logic [NUM_FWD*DATA_W-1:0] fwd_data_o,
   output logic [NUM_FWD-1:0]        fwd_valid_o,
   input  logic                      retire_ready_i,
   output logic                      retire_valid_o,
   output logic [4:0]                retire_dest_o,
   output logic [DATA_W-1:0]         retire_result_o,
   output logic                      retire_exception_o,
   output logic [4:0]                retire_vector_o
);

   logic [TAG_W:0]    head, tail, count;
   logic [TAG_W-1:0]  head_idx, tail_idx;
   logic [DEPTH-1:0]  done_q, exc_q, in_flight, wr_hit, wr_exc;
   logic [4:0]        dest_q   [DEPTH];
   logic [DATA_W-1:0] result_q [DEPTH];
   logic [4:0]        vector_q [DEPTH];
   logic [DATA_W-1:0] wr_res   [DEPTH];
   logic [4:0]        wr_vec   [DEPTH];
   logic              alloc_fire, retire_fire;

   assign head_idx    = head[TAG_W-1:0];
   assign tail_idx    = tail[TAG_W-1:0];
   assign count       = tail - head;
   assign count_o     = count;
   assign empty_o     = (head == tail);
   assign full_o      = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);
   assign alloc_tag_o = tail_idx;
   assign alloc_fire  = alloc_i & ~full_o;

   assign retire_valid_o     = ~empty_o & done_q[head_idx];
   assign retire_fire        = retire_valid_o & retire_ready_i;
   assign retire_dest_o      = dest_q[head_idx];
   assign retire_result_o    = result_q[head_idx];
   assign retire_exception_o = exc_q[head_idx];
   assign retire_vector_o    = vector_q[head_idx];

   // Per-entry write select: an entry is live when its distance from head is
   // below the occupancy, which stays correct across pointer wrap.
   for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      logic [TAG_W-1:0]  off;
      logic              hit, ex;
      logic [DATA_W-1:0] res;
      logic [4:0]        vec;
      assign off          = TAG_W'(i) - head_idx;
      assign in_flight[i] = ({1'b0, off} < count);
      always_comb begin
         hit = 1'b0;
         res = '0;
         ex  = 1'b0;
         vec = '0;
         for (int k = NUM_WR-1; k >= 0; k--) begin
            if (wr_valid_i[k] && (wr_tag_i[k*TAG_W +: TAG_W] == TAG_W'(i))) begin
               hit = 1'b1;
               res = wr_result_i[k*DATA_W +: DATA_W];
               ex  = wr_exception_i[k];
               vec = wr_vector_i[k*5 +: 5];
            end
         end
      end
      assign wr_hit[i] = hit & in_flight[i];
      assign wr_res[i] = res;
      assign wr_exc[i] = ex;
      assign wr_vec[i] = vec;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         head   <= '0;
         tail   <= '0;
         done_q <= '0;
         exc_q  <= '0;
      end else if (flush_i) begin
         head   <= '0;
         tail   <= '0;
         done_q <= '0;
         exc_q  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_hit[i]) begin
               done_q[i] <= 1'b1;
               exc_q[i]  <= wr_exc[i];
            end
         end
         if (alloc_fire) begin
            done_q[tail_idx] <= 1'b0;
            exc_q[tail_idx]  <= 1'b0;
            tail             <= tail + 1'b1;
         end
         if (retire_fire) begin
            done_q[head_idx] <= 1'b0;
            head             <= head + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (alloc_fire) dest_q[tail_idx] <= alloc_dest_i;
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_hit[i]) begin
            result_q[i] <= wr_res[i];
            vector_q[i] <= wr_vec[i];
         end
      end
   end

   // Scan oldest to youngest so the last match is the youngest producer.
   for (genvar j = 0; j < NUM_FWD; j++) begin : g_fwd
      logic [4:0]       src;
      logic             hit, ok;
      logic [TAG_W-1:0] sel;
      assign src = fwd_src_i[j*5 +: 5];
      always_comb begin
         hit = 1'b0;
         sel = '0;
         for (int o = 0; o < DEPTH; o++) begin
            if (((TAG_W+1)'(o) < count) && (dest_q[head_idx + TAG_W'(o)] == src)) begin
               hit = 1'b1;
               sel = head_idx + TAG_W'(o);
            end
         end
      end
      assign ok             = hit & done_q[sel] & ~exc_q[sel] & (src != 5'd0);
      assign fwd_valid_o[j] = ok;
      assign fwd_data_o[j*DATA_W +: DATA_W] = ok ? result_q[sel] : '0;
   end

endmodule
